// File: rtl/register_file_pkg.sv
// register_file_pkg: shared widths and constants for the rename-tagged register file
package register_file_pkg;
    localparam int XLEN = 32;
    localparam int REG_CNT = 32;
    localparam int REG_AW = 5;
    localparam int ROB_W = 32;
    localparam logic TRUE = 1'b1;
    localparam logic FALSE = 1'b0;
endpackage

// File: rtl/register_file_if.sv
// register_file_if: decoder, ROB commit and ROB lookup signals around the register file
interface register_file_if import register_file_pkg::*; #(parameter int TAGW = ROB_W) ();
    logic rdy;
    logic jump_wrong_flag;
    logic ID_inst_flag;
    logic [REG_AW-1:0] ID_inst_rd;
    logic [TAGW-1:0] ID_rob_id;
    logic [REG_AW-1:0] ID_rs1;
    logic [REG_AW-1:0] ID_rs2;
    logic RF_rs1_ready;
    logic RF_rs2_ready;
    logic [XLEN-1:0] RF_rs1_val;
    logic [XLEN-1:0] RF_rs2_val;
    logic [TAGW-1:0] RF_rs1_tag;
    logic [TAGW-1:0] RF_rs2_tag;
    logic ROB_cmt_rf_flag;
    logic [REG_AW-1:0] ROB_cmt_rf_rd;
    logic [TAGW-1:0] ROB_cmt_rf_rob_id;
    logic [XLEN-1:0] ROB_cmt_rf_val;
    logic [TAGW-1:0] RF_id1;
    logic [TAGW-1:0] RF_id2;
    logic RF_id1_ready;
    logic RF_id2_ready;
    logic [XLEN-1:0] RF_id1_val;
    logic [XLEN-1:0] RF_id2_val;
    modport slave (
        input rdy, jump_wrong_flag, ID_inst_flag, ID_inst_rd, ID_rob_id, ID_rs1, ID_rs2,
        input ROB_cmt_rf_flag, ROB_cmt_rf_rd, ROB_cmt_rf_rob_id, ROB_cmt_rf_val,
        input RF_id1_ready, RF_id2_ready, RF_id1_val, RF_id2_val,
        output RF_rs1_ready, RF_rs2_ready, RF_rs1_val, RF_rs2_val, RF_rs1_tag, RF_rs2_tag,
        output RF_id1, RF_id2
    );
    modport master (
        output rdy, jump_wrong_flag, ID_inst_flag, ID_inst_rd, ID_rob_id, ID_rs1, ID_rs2,
        output ROB_cmt_rf_flag, ROB_cmt_rf_rd, ROB_cmt_rf_rob_id, ROB_cmt_rf_val,
        output RF_id1_ready, RF_id2_ready, RF_id1_val, RF_id2_val,
        input RF_rs1_ready, RF_rs2_ready, RF_rs1_val, RF_rs2_val, RF_rs1_tag, RF_rs2_tag,
        input RF_id1, RF_id2
    );
endinterface

// File: rtl/register_file_operand_resolve.sv
// register_file_operand_resolve: turns one source register into a value or a pending ROB id
module register_file_operand_resolve import register_file_pkg::*; #(parameter int TAGW = ROB_W) (
    input  logic [REG_AW-1:0] rs,
    input  logic              busy,
    input  logic [XLEN-1:0]   reg_val,
    input  logic [TAGW-1:0]   reg_tag,
    input  logic              cmt_flag,
    input  logic [REG_AW-1:0] cmt_rd,
    input  logic [TAGW-1:0]   cmt_rob_id,
    input  logic [XLEN-1:0]   cmt_val,
    input  logic              rob_ready,
    input  logic [XLEN-1:0]   rob_val,
    output logic              ready,
    output logic [XLEN-1:0]   val,
    output logic [TAGW-1:0]   tag,
    output logic [TAGW-1:0]   rob_id
);
    logic zero;
    logic bypass;
    // x0 first, then architectural value, then the committing producer, then the ROB's copy
    always_comb begin
        zero   = rs == '0;
        bypass = busy && cmt_flag && cmt_rd == rs && cmt_rob_id == reg_tag;
        ready  = zero || !busy || bypass || rob_ready;
        val    = zero ? '0 : !busy ? reg_val : bypass ? cmt_val : rob_ready ? rob_val : '0;
        tag    = ready ? '0 : reg_tag;
        rob_id = reg_tag;
    end
endmodule

// File: rtl/register_file.sv
// register_file: architectural registers with rename tags, commit writeback and flush
module register_file import register_file_pkg::*; #(
    parameter int REGSZ = REG_CNT,
    parameter int TAGW  = ROB_W
) (
    input logic clk,
    input logic rst,
    register_file_if.slave bus
);
    logic [XLEN-1:0] val_q [REGSZ];
    logic [TAGW-1:0] tag_q [REGSZ];
    logic [REGSZ-1:0] busy_q;
    logic cmt_we;
    logic ren_we;
    // x0 is excluded from both write paths so it can never hold a value or go busy
    always_comb begin
        cmt_we = bus.ROB_cmt_rf_flag && bus.ROB_cmt_rf_rd != '0;
        ren_we = bus.ID_inst_flag && bus.ID_inst_rd != '0;
    end
    // rename is written after the commit release so it wins on a same-rd collision
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            for (int i = 0; i < REGSZ; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (bus.rdy) begin
            if (cmt_we) val_q[bus.ROB_cmt_rf_rd] <= bus.ROB_cmt_rf_val;
            if (bus.jump_wrong_flag) begin
                busy_q <= '0;
            end else begin
                if (cmt_we && tag_q[bus.ROB_cmt_rf_rd] == bus.ROB_cmt_rf_rob_id) busy_q[bus.ROB_cmt_rf_rd] <= FALSE;
                if (ren_we) begin
                    busy_q[bus.ID_inst_rd] <= TRUE;
                    tag_q[bus.ID_inst_rd]  <= bus.ID_rob_id;
                end
            end
        end
    end
    register_file_operand_resolve #(.TAGW(TAGW)) u_rs1 (
        .rs(bus.ID_rs1), .busy(busy_q[bus.ID_rs1]), .reg_val(val_q[bus.ID_rs1]), .reg_tag(tag_q[bus.ID_rs1]),
        .cmt_flag(bus.ROB_cmt_rf_flag), .cmt_rd(bus.ROB_cmt_rf_rd), .cmt_rob_id(bus.ROB_cmt_rf_rob_id),
        .cmt_val(bus.ROB_cmt_rf_val), .rob_ready(bus.RF_id1_ready), .rob_val(bus.RF_id1_val),
        .ready(bus.RF_rs1_ready), .val(bus.RF_rs1_val), .tag(bus.RF_rs1_tag), .rob_id(bus.RF_id1)
    );
    register_file_operand_resolve #(.TAGW(TAGW)) u_rs2 (
        .rs(bus.ID_rs2), .busy(busy_q[bus.ID_rs2]), .reg_val(val_q[bus.ID_rs2]), .reg_tag(tag_q[bus.ID_rs2]),
        .cmt_flag(bus.ROB_cmt_rf_flag), .cmt_rd(bus.ROB_cmt_rf_rd), .cmt_rob_id(bus.ROB_cmt_rf_rob_id),
        .cmt_val(bus.ROB_cmt_rf_val), .rob_ready(bus.RF_id2_ready), .rob_val(bus.RF_id2_val),
        .ready(bus.RF_rs2_ready), .val(bus.RF_rs2_val), .tag(bus.RF_rs2_tag), .rob_id(bus.RF_id2)
    );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench with a behavioural register/rename model
module tb_register_file;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    register_file_if #(.TAGW(32)) bus ();
    register_file #(.REGSZ(32), .TAGW(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        string nm;
        logic r1; logic [31:0] v1; logic [31:0] t1; logic [31:0] i1;
        logic r2; logic [31:0] v2; logic [31:0] t2; logic [31:0] i2;
    } exp_t;
    typedef struct { logic [4:0] rd; logic [31:0] id; } pend_t;

    exp_t sb[$];
    pend_t pend[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_val [32];
    logic [31:0] m_tag [32];
    logic        m_busy [32];

    initial for (int i = 0; i < 32; i++) begin
        m_val[i] = 0; m_tag[i] = 0; m_busy[i] = 0;
    end

    function automatic void resolve(input logic [4:0] s, input logic idr, input logic [31:0] idv,
                                    output logic r, output logic [31:0] v, output logic [31:0] t, output logic [31:0] id);
        id = m_tag[s]; t = 0; v = 0; r = 1;
        if (s == 0) v = 0;
        else if (!m_busy[s]) v = m_val[s];
        else if (bus.ROB_cmt_rf_flag && bus.ROB_cmt_rf_rd == s && bus.ROB_cmt_rf_rob_id == m_tag[s]) v = bus.ROB_cmt_rf_val;
        else if (idr) v = idv;
        else begin r = 0; t = m_tag[s]; end
    endfunction

    function automatic void model_update();
        logic cm, rn;
        cm = bus.ROB_cmt_rf_flag && bus.ROB_cmt_rf_rd != 0;
        rn = bus.ID_inst_flag && bus.ID_inst_rd != 0;
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_tag[i] = 0; m_busy[i] = 0; end
        end else if (bus.rdy) begin
            if (cm) m_val[bus.ROB_cmt_rf_rd] = bus.ROB_cmt_rf_val;
            if (bus.jump_wrong_flag) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else begin
                if (cm && m_tag[bus.ROB_cmt_rf_rd] == bus.ROB_cmt_rf_rob_id && !(rn && bus.ID_inst_rd == bus.ROB_cmt_rf_rd))
                    m_busy[bus.ROB_cmt_rf_rd] = 0;
                if (rn) begin m_busy[bus.ID_inst_rd] = 1; m_tag[bus.ID_inst_rd] = bus.ID_rob_id; end
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.nm, " rs1_ready"}, {31'd0, bus.RF_rs1_ready}, {31'd0, e.r1});
            chk({e.nm, " rs1_val"}, bus.RF_rs1_val, e.v1);
            chk({e.nm, " rs1_tag"}, bus.RF_rs1_tag, e.t1);
            chk({e.nm, " id1"}, bus.RF_id1, e.i1);
            chk({e.nm, " rs2_ready"}, {31'd0, bus.RF_rs2_ready}, {31'd0, e.r2});
            chk({e.nm, " rs2_val"}, bus.RF_rs2_val, e.v2);
            chk({e.nm, " rs2_tag"}, bus.RF_rs2_tag, e.t2);
            chk({e.nm, " id2"}, bus.RF_id2, e.i2);
        end
    end

    task automatic step(input string nm);
        exp_t e;
        e.nm = nm;
        resolve(bus.ID_rs1, bus.RF_id1_ready, bus.RF_id1_val, e.r1, e.v1, e.t1, e.i1);
        resolve(bus.ID_rs2, bus.RF_id2_ready, bus.RF_id2_val, e.r2, e.v2, e.t2, e.i2);
        sb.push_back(e);
        @(posedge clk);
        model_update();
        if (!rst) pend.delete();
        else if (bus.rdy) begin
            if (bus.ROB_cmt_rf_flag && pend.size() != 0 && pend[0].id == bus.ROB_cmt_rf_rob_id) void'(pend.pop_front());
            if (bus.jump_wrong_flag) pend.delete();
            else if (bus.ID_inst_flag) pend.push_back('{bus.ID_inst_rd, bus.ID_rob_id});
        end
        #1;
    endtask

    task automatic idle();
        bus.rdy = 1; bus.jump_wrong_flag = 0;
        bus.ID_inst_flag = 0; bus.ID_inst_rd = 0; bus.ID_rob_id = 0;
        bus.ROB_cmt_rf_flag = 0; bus.ROB_cmt_rf_rd = 0; bus.ROB_cmt_rf_rob_id = 0; bus.ROB_cmt_rf_val = 0;
        bus.RF_id1_ready = 0; bus.RF_id2_ready = 0; bus.RF_id1_val = 0; bus.RF_id2_val = 0;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [31:0] id);
        bus.ID_inst_flag = 1; bus.ID_inst_rd = rd; bus.ID_rob_id = id;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] id, input logic [31:0] v);
        bus.ROB_cmt_rf_flag = 1; bus.ROB_cmt_rf_rd = rd; bus.ROB_cmt_rf_rob_id = id; bus.ROB_cmt_rf_val = v;
    endtask

    task automatic rd2(input logic [4:0] a, input logic [4:0] b);
        bus.ID_rs1 = a; bus.ID_rs2 = b;
    endtask

    logic [31:0] next_id;

    initial begin
        idle(); rd2(5, 0);
        @(posedge clk); #1;
        step("reset");
        rst = 1;
        rename(5, 7); step("rename_x5_t7");
        idle(); step("x5_pending");
        bus.RF_id1_ready = 1; bus.RF_id1_val = 32'h55; step("x5_rob_lookup");
        idle(); commit(5, 7, 32'h1234); step("x5_commit_bypass");
        idle(); step("x5_committed");
        rename(5, 7); step("x5_t7_again");
        idle(); rename(5, 9); step("x5_t9");
        idle(); commit(5, 7, 32'hAA); step("x5_stale_commit");
        idle(); step("x5_still_t9");
        commit(5, 9, 32'hBB); step("x5_commit_t9");
        idle(); step("x5_released");
        rd2(3, 3); commit(3, 4, 32'h333); rename(3, 8); step("x3_collide");
        idle(); step("x3_after_collide");
        rd2(1, 2); rename(1, 10); step("x1_rename");
        idle(); rename(2, 11); step("x2_rename");
        idle(); step("x1_x2_busy");
        commit(1, 10, 32'h77); bus.jump_wrong_flag = 1; rename(4, 12); step("flush_commit");
        idle(); rd2(1, 4); step("after_flush");
        idle(); rd2(2, 0); step("x2_after_flush");
        commit(0, 12, 32'hDEAD); rename(0, 13); rd2(0, 0); step("x0_write");
        idle(); step("x0_read");
        pend.delete();
        next_id = 100;
        for (int n = 0; n < 400; n++) begin
            idle();
            bus.rdy = ($urandom_range(7) != 0);
            rst = ($urandom_range(99) != 0);
            bus.jump_wrong_flag = ($urandom_range(29) == 0);
            if ($urandom_range(1) == 1) rename(5'($urandom_range(7)), next_id);
            next_id++;
            if (pend.size() != 0 && $urandom_range(1) == 1) commit(pend[0].rd, pend[0].id, $urandom);
            else if ($urandom_range(9) == 0) commit(5'($urandom_range(7)), $urandom_range(200), $urandom);
            rd2(5'($urandom_range(7)), 5'($urandom_range(7)));
            bus.RF_id1_ready = ($urandom_range(3) == 0); bus.RF_id1_val = $urandom;
            bus.RF_id2_ready = ($urandom_range(3) == 0); bus.RF_id2_val = $urandom;
            step("random");
        end
        idle(); rst = 1;
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
